multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (PC, IR, register file, ALU, shared instruction/data memory).

---
 rtl/multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  multicycle_ctrl : multi-cycle MIPS sequencer with memory handshake and traps
//  Rev 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 branch_ne,
    output logic [1:0]           pc_source,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 halted,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int C_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST =
        C_WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_MEM = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    state_t                 state_q, state_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [1:0]             err_q, err_d;
    logic [C_WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   instr_q, instr_d;
    logic                   w_waiting;
    logic                   w_timeout;
    logic                   w_boundary;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wait_d     = wait_q;
        cycle_d    = cycle_q;
        instr_d    = instr_q;
        w_boundary = 1'b0;

        w_waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                    && !mem_ready;
        w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (wait_q == C_WAIT_LAST);

        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:        state_d = S_EXEC_R;
                    6'h23, 6'h2B: state_d = S_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08:        state_d = S_EXEC_I;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_ADDR:   state_d = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: w_boundary = mem_ready;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_boundary = 1'b1;
            // A fault halt leaves err_q non-zero, which pins the FSM here until reset
            S_HALT:   if ((err_q == 2'b00) && !halt_req) state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase

        if (w_boundary) begin
            instr_d = instr_q + CNT_WIDTH'(1);
            state_d = halt_req ? S_HALT : S_FETCH;
        end

        if (w_timeout) begin
            state_d = S_HALT;
            err_d   = 2'b10;
        end

        if (w_waiting && (MEM_TIMEOUT != 0)) wait_d = wait_q + C_WAIT_W'(1);
        if (state_d != state_q)              wait_d = '0;

        if ((state_q != S_RST) && (state_q != S_HALT)) cycle_d = cycle_q + CNT_WIDTH'(1);

        // Outputs are decoded from the next state so they are registered Moore outputs
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = 2'd1;
            end
            S_DECODE: ctrl_d.alu_src_b = 2'd3;
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = 2'b10;
            end
            S_EXEC_I, S_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'd2;
            end
            S_WB_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_WB_I:   ctrl_d.reg_write = 1'b1;
            S_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'd1;
                ctrl_d.branch_ne     = (opcode == 6'h05);
            end
            S_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 2'd2;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ctrl_q  <= '0;
            err_q   <= 2'b00;
            wait_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    // The fetch handshake loads IR and PC in the very cycle memory answers
    logic w_fetch_ack;
    assign w_fetch_ack = (state_q == S_FETCH) && mem_ready;

    assign pc_write      = ctrl_q.pc_write | w_fetch_ack;
    assign ir_write      = w_fetch_ack;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign branch_ne     = ctrl_q.branch_ne;
    assign pc_source     = ctrl_q.pc_source;
    assign iord          = ctrl_q.iord;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign halted        = ctrl_q.halted;
    assign error         = |err_q;
    assign err_code      = err_q;
    assign cycle_count   = cycle_q;
    assign instr_count   = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_multicycle_ctrl : directed + randomized bench with per-phase reference
//  Rev 1.0
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic        ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, halted, error;
    logic [1:0]  pc_source, alu_src_b, alu_op, err_code;
    logic [31:0] cycle_count, instr_count;

    multicycle_ctrl #(.CNT_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_source(pc_source), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halted(halted), .error(error), .err_code(err_code),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {P_RST, P_FETCH, P_DECODE, P_EXEC_R, P_WB_R, P_EXEC_I, P_WB_I,
                  P_ADDR, P_MEM_RD, P_WB_MEM, P_MEM_WR, P_BRANCH, P_JUMP, P_HALT} phase_e;

    int          n_total = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cycles = 0;
    logic [31:0] exp_instr  = 0;
    logic [1:0]  exp_ec     = 2'b00;
    logic [5:0]  cur_op     = 6'h00;

    logic [20:0] obs_v;
    assign obs_v = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                    mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                    alu_src_b, alu_op, halted, error, err_code};

    // Expected control word for one cycle of a named instruction phase
    function automatic logic [20:0] expect_ctrl(input phase_e ph, input logic [5:0] op,
                                                input logic rdy, input logic [1:0] ec);
        logic pcw, pcc, bne, ia, rd, wr, irw, rw, rdst, m2r, sa, hlt;
        logic [1:0] src, sb, aop;
        {pcw, pcc, bne, ia, rd, wr, irw, rw, rdst, m2r, sa, hlt} = '0;
        src = 2'd0; sb = 2'd0; aop = 2'd0;
        case (ph)
            P_FETCH:          begin rd = 1'b1; sb = 2'd1; irw = rdy; pcw = rdy; end
            P_DECODE:         sb = 2'd3;
            P_EXEC_R:         begin sa = 1'b1; aop = 2'b10; end
            P_EXEC_I, P_ADDR: begin sa = 1'b1; sb = 2'd2; end
            P_WB_R:           begin rw = 1'b1; rdst = 1'b1; end
            P_WB_I:           rw = 1'b1;
            P_MEM_RD:         begin rd = 1'b1; ia = 1'b1; end
            P_WB_MEM:         begin rw = 1'b1; m2r = 1'b1; end
            P_MEM_WR:         begin wr = 1'b1; ia = 1'b1; end
            P_BRANCH:         begin sa = 1'b1; aop = 2'b01; pcc = 1'b1; src = 2'd1;
                                    bne = (op == 6'h05); end
            P_JUMP:           begin pcw = 1'b1; src = 2'd2; end
            P_HALT:           hlt = 1'b1;
            default:          hlt = 1'b0;
        endcase
        return {pcw, pcc, bne, src, ia, rd, wr, irw, rw, rdst, m2r, sa, sb, aop,
                hlt, (ec != 2'b00), ec};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs/counters, advance the model
    task automatic cyc(input phase_e ph, input logic rdy, input logic hreq, input bit bnd);
        mem_ready = rdy;
        halt_req  = hreq;
        #1;
        check({ph.name(), "_ctrl"}, 64'(obs_v), 64'(expect_ctrl(ph, cur_op, rdy, exp_ec)));
        check({ph.name(), "_cycles"}, 64'(cycle_count), 64'(exp_cycles));
        check({ph.name(), "_instr"}, 64'(instr_count), 64'(exp_instr));
        @(posedge clk);
        #1;
        if (ph != P_RST && ph != P_HALT) exp_cycles++;
        if (bnd) exp_instr++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        halt_req  = 1'b0;
        #1;
        exp_cycles = 0;
        exp_instr  = 0;
        exp_ec     = 2'b00;
        check("reset_ctrl", 64'(obs_v), 64'(0));
        check("reset_cycles", 64'(cycle_count), 64'(0));
        check("reset_instr", 64'(instr_count), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(P_RST, 1'b1, 1'b0, 0);
    endtask

    // fw/mw: wait cycles before fetch / data access completes; hb: halt at boundary
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic hb);
        cur_op = op;
        opcode = op;
        repeat (fw) cyc(P_FETCH, 1'b0, rnd1(), 0);
        cyc(P_FETCH, 1'b1, rnd1(), 0);
        cyc(P_DECODE, rnd1(), rnd1(), 0);
        case (op)
            6'h00: begin
                cyc(P_EXEC_R, rnd1(), rnd1(), 0);
                cyc(P_WB_R, rnd1(), hb, 1);
            end
            6'h08: begin
                cyc(P_EXEC_I, rnd1(), rnd1(), 0);
                cyc(P_WB_I, rnd1(), hb, 1);
            end
            6'h23: begin
                cyc(P_ADDR, rnd1(), rnd1(), 0);
                repeat (mw) cyc(P_MEM_RD, 1'b0, rnd1(), 0);
                cyc(P_MEM_RD, 1'b1, rnd1(), 0);
                cyc(P_WB_MEM, rnd1(), hb, 1);
            end
            6'h2B: begin
                cyc(P_ADDR, rnd1(), rnd1(), 0);
                repeat (mw) cyc(P_MEM_WR, 1'b0, rnd1(), 0);
                cyc(P_MEM_WR, 1'b1, hb, 1);
            end
            6'h04, 6'h05: cyc(P_BRANCH, rnd1(), hb, 1);
            default:      cyc(P_JUMP, rnd1(), hb, 1);
        endcase
        if (hb) begin
            repeat ($urandom_range(0, 2)) cyc(P_HALT, rnd1(), 1'b1, 0);
            cyc(P_HALT, rnd1(), 1'b0, 0);
        end
    endtask

    initial begin
        logic [5:0] legal_ops [7];
        legal_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed: R-type, lw with 3 data waits, beq then bne, jump, addi, sw
        run_instr(6'h00, 0, 0, 1'b0);
        run_instr(6'h23, 0, 3, 1'b0);
        run_instr(6'h04, 0, 0, 1'b0);
        run_instr(6'h05, 0, 0, 1'b0);
        run_instr(6'h02, 0, 0, 1'b0);
        run_instr(6'h08, 0, 0, 1'b0);
        run_instr(6'h2B, 2, 1, 1'b0);

        // Non-fault halt at the boundary of an R-type, then resume
        run_instr(6'h00, 1, 0, 1'b1);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 3),
                      $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        // Illegal opcode: sticky fault halt with frozen counters
        cur_op = 6'h3F;
        opcode = 6'h3F;
        cyc(P_FETCH, 1'b1, 1'b0, 0);
        cyc(P_DECODE, 1'b0, 1'b0, 0);
        exp_ec = 2'b01;
        repeat (4) cyc(P_HALT, rnd1(), 1'b0, 0);

        // Asynchronous reset in the middle of a load's data wait
        do_reset();
        cur_op = 6'h23;
        opcode = 6'h23;
        cyc(P_FETCH, 1'b1, 1'b0, 0);
        cyc(P_DECODE, 1'b1, 1'b0, 0);
        cyc(P_ADDR, 1'b1, 1'b0, 0);
        cyc(P_MEM_RD, 1'b0, 1'b0, 0);
        do_reset();
        cyc(P_FETCH, 1'b0, 1'b0, 0);
        do_reset();

        // Fetch timeout after four unanswered cycles
        cur_op = 6'h00;
        opcode = 6'h00;
        repeat (4) cyc(P_FETCH, 1'b0, 1'b0, 0);
        exp_ec = 2'b10;
        repeat (3) cyc(P_HALT, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
`default_nettype wire
